dc_remove_avg: RTL and testbench

Parametrised DC-removal filter: running mean over the last 2^LOG2_SAMPLES accepted samples, output is current sample minus mean.
Sits after the demodulator/merge stage, replacing the fixed 16-bit/128-sample remover.
Adds a valid-driven pipeline, run-time mode select, synchronous clear, fill status and optional output saturation.

---
 rtl/dcr_pkg.sv | 30 +++
 rtl/dcr_ring_buf.sv | 68 ++++++
 rtl/dc_remove_avg.sv | 145 ++++++++++++++
 tb/tb_dc_remove_avg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dcr_pkg.sv
// Shared constants and helpers for the DC-removal filter.
package dcr_pkg;

  localparam logic [1:0] DCR_MODE_DCR  = 2'd0;
  localparam logic [1:0] DCR_MODE_MEAN = 2'd1;
  localparam logic [1:0] DCR_MODE_BYP  = 2'd2;

  // Running-sum width: one sample plus log2(depth) growth bits, so it can never overflow.
  function automatic int unsigned dcr_sum_width(input int unsigned width,
                                                input int unsigned log2_samples);
    return width + log2_samples;
  endfunction

  // Clamp a sign-extended value to the signed range of 'width' bits (width <= 32).
  function automatic logic signed [32:0] dcr_sat(input logic signed [32:0] val,
                                                 input int unsigned      width);
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (width - 1));
    if (val > hi) begin
      return hi;
    end
    if (val < lo) begin
      return lo;
    end
    return val;
  endfunction

endpackage

// File: rtl/dcr_ring_buf.sv
// History ring for the DC-removal filter: read-before-write sample memory, wrapping write
// pointer and a saturating fill counter that flags when the window is full.
module dcr_ring_buf #(
  parameter int unsigned Width       = 16,
  parameter int unsigned Log2Samples = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] old_o,
  output logic             filled_o
);

  localparam int unsigned Samples = 1 << Log2Samples;
  localparam logic [Log2Samples:0] FullCnt = {1'b1, {Log2Samples{1'b0}}};

  logic [Width-1:0]       mem_q [Samples];
  logic [Log2Samples-1:0] wr_ptr_q, wr_ptr_d;
  logic [Log2Samples:0]   cnt_q, cnt_d;
  logic                   filled_q, filled_d;
  logic [Width-1:0]       old_q, old_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    filled_d = filled_q;
    old_d    = old_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      cnt_d    = '0;
      filled_d = 1'b0;
    end else if (wr_en_i) begin
      // Before the window is full the evicted slot is stale, so it counts as zero.
      old_d    = filled_q ? mem_q[wr_ptr_q] : '0;
      wr_ptr_d = wr_ptr_q + Log2Samples'(1);
      if (cnt_q != FullCnt) begin
        cnt_d = cnt_q + (Log2Samples + 1)'(1);
      end
      filled_d = (cnt_d == FullCnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      filled_q <= 1'b0;
      old_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      filled_q <= filled_d;
      old_q    <= old_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !clear_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign old_o    = old_q;
  assign filled_o = filled_q;

endmodule

// File: rtl/dc_remove_avg.sv
// DC-removal filter: running mean over the last 2^LOG2_SAMPLES samples, two-stage pipeline.
// Define DCR_SAT_EN to clamp the difference and expose sat_o; otherwise the difference wraps.
module dc_remove_avg
  import dcr_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned LOG2_SAMPLES = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             filled_o
`ifdef DCR_SAT_EN
  ,
  output logic             sat_o
`endif
);

  localparam int unsigned SumW  = dcr_sum_width(WIDTH, LOG2_SAMPLES);
  localparam int unsigned DiffW = WIDTH + 1;

  logic accept;
  assign accept = valid_i & ~clear_i;

  // Stage 1 registers.
  logic signed [WIDTH-1:0] x1_q;
  logic [1:0]              mode1_q;
  logic                    v1_q;
  logic [WIDTH-1:0]        old1;

  dcr_ring_buf #(
    .Width      (WIDTH),
    .Log2Samples(LOG2_SAMPLES)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .wr_en_i (accept),
    .data_i  (data_i),
    .old_o   (old1),
    .filled_o(filled_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q    <= '0;
      mode1_q <= '0;
      v1_q    <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        x1_q    <= data_i;
        mode1_q <= mode_i;
      end
    end
  end

  // Stage 2 arithmetic.
  logic signed [SumW-1:0]  sum_q;
  logic signed [SumW-1:0]  sum_n;
  logic signed [WIDTH-1:0] old1_s;
  logic signed [WIDTH-1:0] mean;
  logic signed [DiffW-1:0] diff;
  logic [WIDTH-1:0]        dcr_res;

  assign old1_s = old1;
  assign sum_n  = sum_q + SumW'(x1_q) - SumW'(old1_s);
  assign mean   = WIDTH'(sum_n >>> LOG2_SAMPLES);
  assign diff   = DiffW'(x1_q) - DiffW'(mean);

`ifdef DCR_SAT_EN
  logic signed [32:0] sat_full;
  logic               sat_hit;
  assign sat_full = dcr_sat(33'(diff), WIDTH);
  assign sat_hit  = (sat_full != 33'(diff));
  assign dcr_res  = sat_full[WIDTH-1:0];
`else
  assign dcr_res  = WIDTH'(diff);
`endif

  // Clear wins over the in-flight sample for the sum; its output still uses the old sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (v1_q) begin
      sum_q <= sum_n;
    end
  end

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
`ifdef DCR_SAT_EN
  logic             sat_q, sat_d;
`endif

  always_comb begin
    valid_d = v1_q;
    data_d  = data_q;
`ifdef DCR_SAT_EN
    sat_d   = 1'b0;
`endif
    if (v1_q) begin
      case (mode1_q)
        DCR_MODE_MEAN: data_d = mean;
        DCR_MODE_BYP:  data_d = x1_q;
        default: begin
          data_d = dcr_res;
`ifdef DCR_SAT_EN
          sat_d  = sat_hit;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef DCR_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef DCR_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`ifdef DCR_SAT_EN
  assign sat_o   = sat_q;
`endif

endmodule

// File: tb/tb_dc_remove_avg.sv
// Scoreboard bench for dc_remove_avg with WIDTH=16, LOG2_SAMPLES=3.
module tb_dc_remove_avg;

  localparam int unsigned W = 16;
  localparam int unsigned L = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear_i;
  logic         valid_i;
  logic [1:0]   mode_i;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         filled_o;
`ifdef DCR_SAT_EN
  logic         sat_o;
`endif

  dc_remove_avg #(
    .WIDTH       (W),
    .LOG2_SAMPLES(L)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .valid_i (valid_i),
    .mode_i  (mode_i),
    .data_i  (data_i),
    .valid_o (valid_o),
    .data_o  (data_o),
    .filled_o(filled_o)
`ifdef DCR_SAT_EN
    ,
    .sat_o   (sat_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int           due;
    logic [W-1:0] data;
    logic         sat;
  } exp_t;
  exp_t sb[$];
  exp_t cur;

  // Reference model of the averaging window.
  int m_buf [N];
  int m_ptr, m_cnt, m_sum;

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_sum = 0;
  endtask

  task automatic model_accept(input int x, input logic [1:0] m);
    int   old, mean, diff, res;
    logic s;
    exp_t e;
    old = (m_cnt == N) ? m_buf[m_ptr] : 0;
    m_buf[m_ptr] = x;
    m_ptr = (m_ptr + 1) % N;
    if (m_cnt < N) m_cnt++;
    m_sum = m_sum + x - old;
    mean = m_sum / N;
    if (m_sum < 0 && (m_sum % N) != 0) mean = mean - 1;
    diff = x - mean;
    s = 1'b0;
    if (m == 2'd1) begin
      res = mean;
    end else if (m == 2'd2) begin
      res = x;
    end else begin
      res = diff;
`ifdef DCR_SAT_EN
      if (diff > 32767) begin
        res = 32767;
        s = 1'b1;
      end else if (diff < -32768) begin
        res = -32768;
        s = 1'b1;
      end
`endif
    end
    e.due  = cyc + 2;
    e.data = W'(res);
    e.sat  = s;
    sb.push_back(e);
  endtask

  // Called at negedge+1; holds inputs for one full cycle, then checks filled_o.
  task automatic send(input logic v, input logic c, input logic [1:0] m, input int x);
    valid_i = v;
    clear_i = c;
    mode_i  = m;
    data_i  = W'(x);
    if (c) model_reset();
    else if (v) model_accept(x, m);
    @(negedge clk);
    #1;
    check("filled_o", 32'(filled_o), 32'(m_cnt == N));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        cur = sb.pop_front();
        check("valid_o", 32'(valid_o), 32'd1);
        check("data_o", 32'(data_o), 32'(cur.data));
`ifdef DCR_SAT_EN
        check("sat_o", 32'(sat_o), 32'(cur.sat));
`endif
      end else begin
        check("valid_o_idle", 32'(valid_o), 32'd0);
      end
    end
  end

  initial begin
    rst     = 1'b0;
    clear_i = 1'b0;
    valid_i = 1'b0;
    mode_i  = 2'd0;
    data_i  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_filled_o", 32'(filled_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;

    // Warm-up ramp: 88,75,63,50,38,25,13,0; filled with the 8th accept.
    for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 2'd0, 100);
    // Clear with a sample on valid_i: the sample is dropped, the 8th still completes.
    send(1'b1, 1'b1, 2'd0, 500);
    send(1'b1, 1'b0, 2'd0, 100);
    // Bypass with gaps, then a mode-3 sample.
    send(1'b1, 1'b0, 2'd2, 1234);
    send(1'b0, 1'b0, 2'd2, 0);
    send(1'b0, 1'b0, 2'd2, 0);
    send(1'b1, 1'b0, 2'd2, 1234);
    send(1'b1, 1'b0, 2'd3, 300);
    send(1'b0, 1'b0, 2'd0, 0);

    // Constant -1: mean floors to -1.
    send(1'b0, 1'b1, 2'd0, 0);
    for (int i = 0; i < 10; i++) send(1'b1, 1'b0, 2'd0, -1);
    for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 2'd1, -1);

    // Extreme step: mean -24577, difference overflows 16 bits.
    send(1'b0, 1'b1, 2'd0, 0);
    for (int i = 0; i < 7; i++) send(1'b1, 1'b0, 2'd0, -32768);
    send(1'b1, 1'b0, 2'd0, 32767);
    send(1'b1, 1'b0, 2'd1, 0);
    send(1'b0, 1'b0, 2'd0, 0);
    send(1'b0, 1'b0, 2'd0, 0);

    // Async reset mid-burst after the window has filled.
    send(1'b0, 1'b1, 2'd0, 0);
    for (int i = 0; i < 9; i++) send(1'b1, 1'b0, 2'd0, 7 * i);
    rst     = 1'b0;
    valid_i = 1'b0;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_data_o", 32'(data_o), 32'd0);
    check("midrst_filled_o", 32'(filled_o), 32'd0);
    sb.delete();
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    send(1'b1, 1'b0, 2'd0, 100);
    send(1'b1, 1'b0, 2'd0, 100);
    for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 2'd0, 0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
